// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions for elastic stage registers.
// Holds the skid-buffer occupancy state, an example stage payload bundle
// and a helper that maps occupancy state to a beat count.
package pipe_skid_reg_pkg;

  // Occupancy of the two-entry skid register; value 2'd3 is unused and
  // recovers to ST_EMPTY.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // Decode -> execute bundle; packed to WIDTH at the instantiation site.
  typedef struct packed {
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } dec_ex_t;

  localparam int unsigned DEC_EX_W = $bits(dec_ex_t);

  function automatic logic [1:0] occupancy(input skid_state_e st);
    case (st)
      ST_ONE:  occupancy = 2'd1;
      ST_TWO:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter for pipeline performance statistics.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset (counter -> 0)
//   clr_i - synchronous clear, wins over inc_i
//   inc_i - increment request; held at all-ones once saturated
//   cnt_o - current count
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage register with a two-entry skid buffer.
// InReady and OutValid are registered, so no combinational path exists
// between the upstream and downstream handshakes.
// Ports:
//   CLK, Reset          - clock, asynchronous active-high reset
//   Flush               - squash stored beats and any beat accepted now
//   InValid/InReady/InData    - upstream handshake and payload
//   OutValid/OutReady/OutData - downstream handshake and head payload
//   Count               - occupancy 0..2
//   StatClear           - synchronous clear of StallCount
//   StallCount          - saturating count of OutValid & !OutReady cycles
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter bit          CLEAR_DATA = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutData,
  output logic [1:0]       Count,
  input  logic             StatClear,
  output logic [CNT_W-1:0] StallCount
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [1:0]       count_q;

  logic in_fire;
  logic out_fire;

  assign in_fire  = InValid & in_ready_q;
  assign out_fire = out_valid_q & OutReady;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (Flush) begin
      // An accepted beat this cycle is dropped; a delivered one completes.
      state_d = ST_EMPTY;
      if (CLEAR_DATA) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = InData;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = InData;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end else if (in_fire) begin
            state_d = ST_TWO;
            skid_d  = InData;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Handshake flags and occupancy are registered from the next state so
  // they change together with the state they describe.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
      count_q     <= occupancy(state_d);
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = out_valid_q;
  assign OutData  = main_q;
  assign Count    = count_q;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk   (CLK),
    .rst   (Reset),
    .clr_i (StatClear),
    .inc_i (out_valid_q & ~OutReady),
    .cnt_o (StallCount)
  );

endmodule
